// File: rtl/load_store_unit.sv
// Load/store unit between a RISC-V style core and a byte-addressed data memory.
// Misaligned halfword/word accesses are split into single-byte beats.
module load_store_unit #(
    parameter logic [2:0] RD_IDLE = 3'b111,
    parameter logic [2:0] WR_IDLE = 3'b111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [2:0]  ReadControl,
    output logic [2:0]  WriteControl,
    output logic [7:0]  Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_isStore;
    logic [2:0]  r_funct3;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_misaligned;
    logic [1:0]  r_beat;

    logic        w_accept;
    logic        w_reqIllegal;
    logic        w_reqMisaligned;
    logic        w_lastBeat;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_reqIllegal = 1'b1;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_reqIllegal = 1'b0;
            3'b100, 3'b101:         w_reqIllegal = req_is_store;
            default:                w_reqIllegal = 1'b1;
        endcase
    end

    // funct3[1:0] encodes the access size for every legal code: 00 byte, 01 half, 10 word
    assign w_reqMisaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                             ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    assign w_lastBeat = !r_misaligned ||
                        (r_beat == ((r_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = w_reqIllegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_lastBeat) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_isStore    <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= 8'h00;
            r_wdata      <= 32'h0;
            r_rdata      <= 32'h0;
            r_err        <= 1'b0;
            r_misaligned <= 1'b0;
            r_beat       <= 2'd0;
        end else if (w_accept) begin
            r_isStore    <= req_is_store;
            r_funct3     <= req_funct3;
            r_addr       <= req_addr;
            r_wdata      <= req_wdata;
            r_rdata      <= 32'h0;
            r_err        <= w_reqIllegal;
            r_misaligned <= w_reqMisaligned;
            r_beat       <= 2'd0;
        end else if (r_state == S_ACCESS) begin
            if (!r_isStore) begin
                if (r_misaligned) begin
                    r_rdata[{r_beat, 3'b000} +: 8] <= ReadData[7:0];
                end else begin
                    r_rdata <= ReadData;
                end
            end
            r_beat <= r_beat + 2'd1;
        end
    end

    // Aligned beats hand funct3 straight to memory; misaligned beats use sb/lbu per byte
    always_comb begin
        ReadControl  = RD_IDLE;
        WriteControl = WR_IDLE;
        Address      = 8'h00;
        WriteData    = 32'h0;
        if (r_state == S_ACCESS) begin
            if (r_misaligned) begin
                Address = r_addr + {6'b000000, r_beat};
                if (r_isStore) begin
                    WriteControl = 3'b000;
                    WriteData    = {24'h0, r_wdata[{r_beat, 3'b000} +: 8]};
                end else begin
                    ReadControl = 3'b100;
                end
            end else begin
                Address = r_addr;
                if (r_isStore) begin
                    WriteControl = r_funct3;
                    WriteData    = r_wdata;
                end else begin
                    ReadControl = r_funct3;
                end
            end
        end
    end

    // Assembled misaligned bytes are zero-filled above, so only lh needs extension here
    always_comb begin
        resp_rdata = 32'h0;
        if ((r_state == S_RESP) && !r_err && !r_isStore) begin
            if (r_misaligned && (r_funct3 == 3'b001)) begin
                resp_rdata = {{16{r_rdata[15]}}, r_rdata[15:0]};
            end else begin
                resp_rdata = r_rdata;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array memory model answers the
// unit, expected responses are queued at issue and checked by a monitor.
module tb_load_store_unit;

    localparam logic [2:0] RD_IDLE = 3'b111;
    localparam logic [2:0] WR_IDLE = 3'b111;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [2:0]  ReadControl;
    logic [2:0]  WriteControl;
    logic [7:0]  Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    load_store_unit #(.RD_IDLE(RD_IDLE), .WR_IDLE(WR_IDLE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ReadControl(ReadControl), .WriteControl(WriteControl),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          latency;
        int          beats;
        logic [7:0]  firstA;
        logic [7:0]  lastA;
        logic [2:0]  ctrl;
    } exp_t;

    exp_t        sb[$];
    int          testsRun = 0;
    int          testsFailed = 0;

    logic [7:0]  mem [0:255];
    logic        clearMem;
    logic        tbWrEn;
    logic [7:0]  tbWrAddr;
    logic [7:0]  tbWrData;
    logic [7:0]  a0, a1, a2, a3;

    int          cycleCount = 0;
    int          acceptCycle = 0;
    int          beatCount = 0;
    logic [7:0]  firstAddr = 8'h00;
    logic [7:0]  lastAddr = 8'h00;
    logic [2:0]  firstCtrl = 3'b000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: reads are combinational and follow the RISC-V load codes
    always_comb begin
        a0 = Address;
        a1 = Address + 8'd1;
        a2 = Address + 8'd2;
        a3 = Address + 8'd3;
        ReadData = 32'h0;
        case (ReadControl)
            3'b000:  ReadData = {{24{mem[a0][7]}}, mem[a0]};
            3'b001:  ReadData = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b010:  ReadData = {mem[a3], mem[a2], mem[a1], mem[a0]};
            3'b100:  ReadData = {24'h0, mem[a0]};
            3'b101:  ReadData = {16'h0, mem[a1], mem[a0]};
            default: ReadData = 32'h0;
        endcase
    end

    // Memory writes happen on the clock edge; bench preload/clear share this process
    always @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (tbWrEn) begin
            mem[tbWrAddr] <= tbWrData;
        end else begin
            case (WriteControl)
                3'b000: mem[Address] <= WriteData[7:0];
                3'b001: begin
                    mem[Address]        <= WriteData[7:0];
                    mem[Address + 8'd1] <= WriteData[15:8];
                end
                3'b010: begin
                    mem[Address]        <= WriteData[7:0];
                    mem[Address + 8'd1] <= WriteData[15:8];
                    mem[Address + 8'd2] <= WriteData[23:16];
                    mem[Address + 8'd3] <= WriteData[31:24];
                end
                default: ;
            endcase
        end
    end

    // Per-transaction observation: accept cycle, beat count, first/last beat address
    always @(posedge clk) begin
        if (req_valid && req_ready && !rst) begin
            acceptCycle <= cycleCount;
            beatCount   <= 0;
        end else if ((ReadControl != RD_IDLE) || (WriteControl != WR_IDLE)) begin
            if (beatCount == 0) begin
                firstAddr <= Address;
                firstCtrl <= (ReadControl != RD_IDLE) ? ReadControl : WriteControl;
            end
            lastAddr  <= Address;
            beatCount <= beatCount + 1;
        end
        cycleCount <= cycleCount + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every response pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected resp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, " rdata"}, resp_rdata, e.rdata);
                checkOutput({e.name, " err"}, {31'h0, resp_err}, {31'h0, e.err});
                checkOutput({e.name, " latency"}, cycleCount - acceptCycle, e.latency);
                checkOutput({e.name, " beats"}, beatCount, e.beats);
                if (e.beats > 0) begin
                    checkOutput({e.name, " first addr"}, {24'h0, firstAddr}, {24'h0, e.firstA});
                    checkOutput({e.name, " last addr"}, {24'h0, lastAddr}, {24'h0, e.lastA});
                    checkOutput({e.name, " beat ctrl"}, {29'h0, firstCtrl}, {29'h0, e.ctrl});
                end
            end
        end
    end

    task automatic pokeByte(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        tbWrEn   = 1'b1;
        tbWrAddr = addr;
        tbWrData = data;
        @(negedge clk);
        tbWrEn   = 1'b0;
    endtask

    task automatic pokeWord(input logic [7:0] addr, input logic [31:0] data);
        for (int k = 0; k < 4; k++) pokeByte(addr + 8'(k), data[8*k +: 8]);
    endtask

    task automatic wipeMem();
        @(negedge clk);
        clearMem = 1'b1;
        @(negedge clk);
        clearMem = 1'b0;
    endtask

    function automatic logic [31:0] memWord(input logic [7:0] addr);
        logic [7:0] b1, b2, b3;
        b1 = addr + 8'd1;
        b2 = addr + 8'd2;
        b3 = addr + 8'd3;
        return {mem[b3], mem[b2], mem[b1], mem[addr]};
    endfunction

    task automatic applyStimulus(input string name, input logic isStore, input logic [2:0] funct3,
                                 input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int latency, input int beats,
                                 input logic [7:0] firstA, input logic [7:0] lastA,
                                 input logic [2:0] ctrl);
        exp_t e;
        int   guard;
        e.name = name;     e.rdata = expRdata; e.err = expErr;
        e.latency = latency; e.beats = beats;
        e.firstA = firstA; e.lastA = lastA; e.ctrl = ctrl;
        @(negedge clk);
        req_is_store = isStore;
        req_funct3   = funct3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) checkOutput({name, " completion timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 8'h00; req_wdata = 32'h0;
        clearMem = 1'b1; tbWrEn = 1'b0; tbWrAddr = 8'h00; tbWrData = 8'h00;
        repeat (2) @(negedge clk);
        clearMem = 1'b0;

        checkOutput("reset req_ready", {31'h0, req_ready}, 32'd1);
        checkOutput("reset resp_valid", {31'h0, resp_valid}, 32'd0);
        checkOutput("reset resp_rdata", resp_rdata, 32'h0);
        checkOutput("reset resp_err", {31'h0, resp_err}, 32'd0);
        checkOutput("reset ReadControl", {29'h0, ReadControl}, 32'h7);
        checkOutput("reset WriteControl", {29'h0, WriteControl}, 32'h7);
        checkOutput("reset Address", {24'h0, Address}, 32'h0);
        checkOutput("reset WriteData", WriteData, 32'h0);
        rst = 1'b0;

        // Misaligned and aligned word loads
        pokeWord(8'h10, 32'h44332211);
        pokeWord(8'h14, 32'h88776655);
        applyStimulus("lw 0x11", 1'b0, 3'b010, 8'h11, 32'h0, 32'h55443322, 1'b0, 5, 4, 8'h11, 8'h14, 3'b100);
        applyStimulus("lw 0x10", 1'b0, 3'b010, 8'h10, 32'h0, 32'h44332211, 1'b0, 2, 1, 8'h10, 8'h10, 3'b010);

        // Misaligned half loads wrapping from 0xFF to 0x00
        pokeByte(8'hFF, 8'h80);
        pokeByte(8'h00, 8'h90);
        applyStimulus("lh 0xFF", 1'b0, 3'b001, 8'hFF, 32'h0, 32'hFFFF9080, 1'b0, 3, 2, 8'hFF, 8'h00, 3'b100);
        applyStimulus("lhu 0xFF", 1'b0, 3'b101, 8'hFF, 32'h0, 32'h00009080, 1'b0, 3, 2, 8'hFF, 8'h00, 3'b100);

        // Misaligned word store
        wipeMem();
        applyStimulus("sw 0x22", 1'b1, 3'b010, 8'h22, 32'hDEADBEEF, 32'h0, 1'b0, 5, 4, 8'h22, 8'h25, 3'b000);
        checkOutput("sw 0x22 word 0x20", memWord(8'h20), 32'hBEEF0000);
        checkOutput("sw 0x22 word 0x24", memWord(8'h24), 32'h0000DEAD);

        // Aligned byte loads
        pokeWord(8'h10, 32'h84332211);
        applyStimulus("lb 0x13", 1'b0, 3'b000, 8'h13, 32'h0, 32'hFFFFFF84, 1'b0, 2, 1, 8'h13, 8'h13, 3'b000);
        applyStimulus("lbu 0x13", 1'b0, 3'b100, 8'h13, 32'h0, 32'h00000084, 1'b0, 2, 1, 8'h13, 8'h13, 3'b100);

        // Illegal encodings respond next cycle with no memory traffic
        applyStimulus("load f3=011", 1'b0, 3'b011, 8'h00, 32'h0, 32'h0, 1'b1, 1, 0, 8'h00, 8'h00, 3'b000);
        applyStimulus("store f3=100", 1'b1, 3'b100, 8'h30, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 8'h00, 8'h00, 3'b000);
        checkOutput("illegal store word 0x30", memWord(8'h30), 32'h0);

        // Aligned and misaligned half stores
        applyStimulus("sh 0x40", 1'b1, 3'b001, 8'h40, 32'h1234ABCD, 32'h0, 1'b0, 2, 1, 8'h40, 8'h40, 3'b001);
        checkOutput("sh 0x40 word", memWord(8'h40), 32'h0000ABCD);
        applyStimulus("sh 0x41", 1'b1, 3'b001, 8'h41, 32'h00005A6B, 32'h0, 1'b0, 3, 2, 8'h41, 8'h42, 3'b000);
        checkOutput("sh 0x41 word", memWord(8'h40), 32'h005A6BCD);

        // Reset in the middle of a misaligned store: two beats land, no response
        wipeMem();
        @(negedge clk);
        req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 8'h22;
        req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort req_ready in rst", {31'h0, req_ready}, 32'd1);
        checkOutput("abort resp_valid in rst", {31'h0, resp_valid}, 32'd0);
        checkOutput("abort WriteControl in rst", {29'h0, WriteControl}, 32'h7);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort word 0x20", memWord(8'h20), 32'hBEEF0000);
        checkOutput("abort word 0x24", memWord(8'h24), 32'h0);

        applyStimulus("lw 0x20 after abort", 1'b0, 3'b010, 8'h20, 32'h0, 32'hBEEF0000, 1'b0, 2, 1, 8'h20, 8'h20, 3'b010);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter RD_IDLE, default 3'b111, ReadControl code driven when no load beat is active (memory returns 0).
REQ-002 SHALL have parameter WR_IDLE, default 3'b111, WriteControl code driven when no store beat is active (memory performs no write).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  core request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_is_store  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RISC-V funct3 (load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw).
REQ-009 SHALL have port req_addr  input  8  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  illegal funct3, qualified by resp_valid.
REQ-014 SHALL have port ReadControl  output  3  to data memory.
REQ-015 SHALL have port WriteControl  output  3  to data memory.
REQ-016 SHALL have port Address  output  8  to data memory.
REQ-017 SHALL have port WriteData  output  32  to data memory.
REQ-018 SHALL have port ReadData  input  32  from data memory, combinational w.r.t. Address/ReadControl.

Function
REQ-019 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-020 SHALL accept a request on a posedge with req_valid & req_ready and latch is_store, funct3, addr, wdata.
REQ-021 SHALL treat funct3 011, 110, 111 (load) and any funct3 other than 000/001/010 (store) as illegal: IDLE -> RESP directly, no memory access, resp_err = 1, resp_rdata = 0.
REQ-022 SHALL classify as misaligned: half (001/101) with addr[0] = 1; word (010) with addr[1:0] != 0; bytes never misaligned.
REQ-023 SHALL perform an aligned access as one ACCESS beat with ReadControl (load) or WriteControl (store) = latched funct3, Address = addr, WriteData = wdata.
REQ-024 SHALL perform a misaligned access as N byte beats (N = 2 half, 4 word), beat k one cycle each, Address = (addr + k) mod 256 (wrap 255 -> 0).
REQ-025 SHALL drive, for misaligned store beat k, WriteControl = 000, WriteData = {24'b0, wdata byte k}.
REQ-026 SHALL drive, for misaligned load beat k, ReadControl = 100 and capture ReadData[7:0] into result byte k at the end of the beat.
REQ-027 SHALL finish a misaligned load with sign extension from bit 15 (lh) or zero extension (lhu); lw passes the 32 assembled bits.
REQ-028 SHALL capture ReadData in full at the end of an aligned load beat.
REQ-029 SHALL drive ReadControl = RD_IDLE, WriteControl = WR_IDLE, Address = 0, WriteData = 0 outside ACCESS, and the unused control at its idle code during ACCESS.
REQ-030 SHALL assert resp_valid for exactly one cycle in RESP; accept at edge T gives resp_valid in cycle T+2 (aligned), T+3 (misaligned half), T+5 (misaligned word), T+1 (illegal).
REQ-031 SHALL ignore req_valid outside IDLE; requests are back-to-back at most once every N+2 cycles.

Reset
REQ-032 SHALL, on rst high, immediately enter IDLE, clear the beat counter and latched data; outputs req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, memory controls idle, Address = 0, WriteData = 0.
REQ-033 SHALL abort an in-flight access on reset without response; store beats already committed are not undone.

Verification
REQ-034 Memory word 0x10 = 0x44332211, 0x14 = 0x88776655; lw at 0x11 -> four beats at 0x11..0x14, resp_rdata = 0x55443322 at T+5, resp_err = 0.
REQ-035 Byte 0xFF = 0x80, byte 0x00 = 0x90; lh at 0xFF -> beats at 0xFF then 0x00, resp_rdata = 0xFFFF9080 at T+3; lhu -> 0x00009080.
REQ-036 Memory cleared; sw 0xDEADBEEF at 0x22 -> word 0x20 = 0xBEEF0000, word 0x24 = 0x0000DEAD, resp_rdata = 0 at T+5.
REQ-037 Aligned lb at 0x13 with word 0x10 = 0x84332211 -> single beat ReadControl = 000, resp_rdata = 0xFFFFFF84 at T+2.
REQ-038 Load funct3 = 011 at 0x00 -> resp_valid & resp_err at T+1, no ACCESS cycle, memory unchanged.
REQ-039 Misaligned sw 0xDEADBEEF at 0x22, rst pulsed after beat 1 -> only bytes 0x22 = 0xEF, 0x23 = 0xBE written, no resp_valid, req_ready = 1 during rst.
